// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder: one 4-bit ripple slice reused across
// NIBBLES cycles, carry held in a register between nibbles.

module nibble_rca4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_cout
);

   logic [4:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar k = 0; k < 4; k++) begin : g_fa
      assign o_sum[k]  = i_a[k] ^ i_b[k] ^ w_c[k];
      assign w_c[k+1]  = (i_a[k] & i_b[k])
                       | (w_c[k] & (i_a[k] ^ i_b[k]));
   end

   assign o_cout = w_c[4];

endmodule

module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic [3:0]       w_nsum;
   logic             w_ncout;
   logic             w_last;
   logic             w_accept;
   logic [WIDTH-1:0] w_acc_next;
   logic [WIDTH-1:0] w_a_next;
   logic [WIDTH-1:0] w_b_next;

   nibble_rca4 u_slice (
      .i_a    (r_a[3:0]),
      .i_b    (r_b[3:0]),
      .i_cin  (r_carry),
      .o_sum  (w_nsum),
      .o_cout (w_ncout)
   );

   // Result fills from the MSB end so nibble 0 lands at the bottom
   // after NIBBLES shifts; the WIDTH==4 case has nothing to shift.
   if (NIBBLES == 1) begin : g_one
      assign w_acc_next = w_nsum;
      assign w_a_next   = '0;
      assign w_b_next   = '0;
   end else begin : g_many
      assign w_acc_next = {w_nsum, r_acc[WIDTH-1:4]};
      assign w_a_next   = {4'b0000, r_a[WIDTH-1:4]};
      assign w_b_next   = {4'b0000, r_b[WIDTH-1:4]};
   end

   assign w_last   = (r_cnt == CW'(NIBBLES - 1));
   assign w_accept = in_valid && r_in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_carry    <= cin;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc   <= w_acc_next;
               r_a     <= w_a_next;
               r_b     <= w_b_next;
               r_carry <= w_ncout;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_sum       <= w_acc_next;
                  r_cout      <= w_ncout;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16): vector table
// plus backpressure, mid-run reset and back-to-back sequences.

module tb_nibble_serial_adder;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [15:0] va;
      logic [15:0] vb;
      logic        vcin;
      logic [15:0] esum;
      logic        ecout;
   } vec_t;

   vec_t vecs[7];

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Presents one operand set, waits for the result and checks
   // latency, sum and cout; optionally consumes it.
   task automatic run_op(input logic [15:0] ta,
                         input logic [15:0] tb,
                         input logic        tc,
                         input logic [15:0] es,
                         input logic        ec,
                         input bit          consume);
      int lat;
      int w;
      a        = ta;
      b        = tb;
      cin      = tc;
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      check("in_ready_wait", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("in_ready_run", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("latency", 32'(lat), 32'(NIB));
      check("sum", 32'(sum), 32'(es));
      check("cout", 32'(cout), 32'(ec));
      if (consume) begin
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         check("ov_after_consume", 32'(out_valid), 32'd0);
         check("ir_after_consume", 32'(in_ready), 32'd1);
         check("sum_hold_idle", 32'(sum), 32'(es));
      end
   endtask

   initial begin
      logic [15:0] qa[$];
      logic [15:0] qb[$];
      logic        qc[$];
      int          n_in;
      int          n_out;
      int          last_t;
      int          cyc;
      logic [16:0] ref_v;

      n_checks = 0;
      n_fail   = 0;

      vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
      vecs[3] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);

      for (int i = 0; i < 7; i++)
         run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin,
                vecs[i].esum, vecs[i].ecout, 1'b1);

      // Backpressure: DONE held while inputs wiggle
      run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         a        = 16'h1111 * 16'(i);
         b        = ~a;
         tick();
         check("bp_sum", 32'(sum), 32'h1000);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_release_ir", 32'(in_ready), 32'd1);
      check("bp_release_ov", 32'(out_valid), 32'd0);

      // Reset after two RUN cycles aborts the operation
      a        = 16'hFFFF;
      b        = 16'h0001;
      cin      = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ov", 32'(out_valid), 32'd0);
      check("abort_ir", 32'(in_ready), 32'd1);
      check("abort_sum", 32'(sum), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("abort_no_pulse", 32'(out_valid), 32'd0);
      end
      run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1);

      // Back-to-back with in_valid/out_ready held high
      n_in      = 0;
      n_out     = 0;
      last_t    = -1;
      cyc       = 0;
      out_ready = 1'b1;
      while (n_out < 3 && cyc < 100) begin
         if (out_valid) begin
            ref_v = {1'b0, qa[n_out]} + {1'b0, qb[n_out]}
                  + 17'(qc[n_out]);
            check("b2b_sum", 32'(sum), 32'(ref_v[15:0]));
            check("b2b_cout", 32'(cout), 32'(ref_v[16]));
            if (last_t >= 0)
               check("b2b_period", 32'(cyc - last_t), 32'(NIB + 2));
            last_t = cyc;
            n_out++;
         end
         if (in_ready && n_in < 3) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            qa.push_back(a);
            qb.push_back(b);
            qc.push_back(cin);
            in_valid = 1'b1;
            n_in++;
         end else if (in_ready) begin
            in_valid = 1'b0;
         end
         tick();
         cyc++;
      end
      check("b2b_count", 32'(n_out), 32'd3);
      in_valid  = 1'b0;
      out_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
